// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter:
// FSM state encoding, default widths and a state helper.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 30;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    D_WAIT,
    I_WAIT,
    D_RESP,
    I_RESP
  } arb_state_e;

  function automatic logic is_wait(arb_state_e s);
    return (s == D_WAIT) || (s == I_WAIT);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory handshake bundle for the arbiter.
// master: arbiter view; slave: pipeline + memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;

  modport master (
    input  i_req, i_addr, i_flush,
    output i_rdata, i_ready,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ready,
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ack
  );

  modport slave (
    output i_req, i_addr, i_flush,
    input  i_rdata, i_ready,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ack
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Wait-state watchdog: counts cycles spent in *_WAIT and fires
// expire_o on the last allowed one; timeout_o is sticky until reset.
// Ports: clk, reset (sync, active-low), in_wait_i, ack_i,
//        expire_o, timeout_o.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic in_wait_i,
  input  logic ack_i,
  output logic expire_o,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  // Leaving the wait state zeroes the count, so every
  // new wait starts from zero.
  always_comb begin
    cnt_d = '0;
    if (in_wait_i)
      cnt_d = cnt_q + CW'(1);
  end

  // An ack on the final cycle still wins.
  assign expire_o = in_wait_i && !ack_i &&
                    (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  assign to_d      = to_q | expire_o;
  assign timeout_o = to_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported variable-latency memory between fetch
// (read-only) and data (read/write); one transaction at a time.
// Ports: clk, reset (sync, active-low), bus (master modport:
// i_*, d_*, m_* handshakes), busy; timeout with MEM_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.master bus,
  output logic busy
`ifdef MEM_TIMEOUT_EN
  ,
  output logic timeout
`endif
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              disc_q, disc_d;
  logic              in_wait;
  logic              expire;

  assign in_wait = is_wait(state_q);

`ifdef MEM_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk      (clk),
    .reset    (reset),
    .in_wait_i(in_wait),
    .ack_i    (bus.m_ack),
    .expire_o (expire),
    .timeout_o(timeout)
  );
`else
  assign expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state: data outranks fetch since it is the older
  // instruction in the pipe.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.d_req)
          state_d = D_WAIT;
        else if (bus.i_req && !bus.i_flush)
          state_d = I_WAIT;
      end
      D_WAIT: if (bus.m_ack) state_d = D_RESP;
      I_WAIT: if (bus.m_ack) state_d = I_RESP;
      D_RESP: state_d = IDLE;
      I_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (expire)
      state_d = IDLE;
  end

  // Request latch, response capture and fetch discard
  always_comb begin
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    disc_d   = disc_q;
    if (state_q == IDLE) begin
      if (bus.d_req) begin
        addr_d  = bus.d_addr;
        we_d    = bus.d_we;
        wdata_d = bus.d_wdata;
      end else if (bus.i_req && !bus.i_flush) begin
        addr_d = bus.i_addr;
        we_d   = 1'b0;
      end
    end
    if (state_q == D_WAIT && bus.m_ack)
      drdata_d = we_q ? '0 : bus.m_rdata;
    if (state_q == I_WAIT && bus.m_ack)
      irdata_d = bus.m_rdata;
    // The read cannot be aborted, only its answer dropped.
    if (state_q == I_WAIT && bus.i_flush)
      disc_d = 1'b1;
    if (state_d == IDLE)
      disc_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      disc_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      disc_q   <= disc_d;
    end
  end

  // Outputs
  always_comb begin
    bus.m_req   = in_wait;
    bus.m_we    = in_wait && we_q;
    bus.m_addr  = addr_q;
    bus.m_wdata = wdata_q;
    bus.d_ready = (state_q == D_RESP);
    bus.d_rdata = drdata_q;
    bus.i_ready = (state_q == I_RESP) &&
                  !disc_q && !bus.i_flush;
    bus.i_rdata = irdata_q;
    busy        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus
// randomized transactions against a transaction-level model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic busy;
`ifdef MEM_TIMEOUT_EN
  logic timeout;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] last_i;
  bit          i_known;
  logic [31:0] last_d;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(30), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(30),
    .DATA_W(32)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master),
    .busy (busy)
`ifdef MEM_TIMEOUT_EN
    ,
    .timeout(timeout)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk();
    step();
    chk("idle_busy", busy, 0);
    chk("idle_mreq", bus.m_req, 0);
    chk("idle_irdy", bus.i_ready, 0);
    chk("idle_drdy", bus.d_ready, 0);
    bus.i_flush = 1'b0;
  endtask

  // Called right after the grant edge. fmode: 0 none,
  // 1 flush while waiting, 2 flush in the response cycle.
  task automatic serve(input bit is_d, input bit we,
                       input logic [29:0] addr,
                       input logic [31:0] wdata,
                       input int lat,
                       input logic [31:0] rdata,
                       input int fmode);
    chk("grant_mreq", bus.m_req, 1);
    chk("grant_busy", busy, 1);
    chk("grant_addr", bus.m_addr, addr);
    chk("grant_we", bus.m_we, is_d && we);
    if (is_d && we)
      chk("grant_wdata", bus.m_wdata, wdata);
    if (fmode == 1) begin
      bus.i_flush = 1'b1;
      bus.i_req   = 1'b0;
    end
    for (int c = 0; c < lat; c++) begin
      step();
      bus.i_flush = 1'b0;
      chk("wait_mreq", bus.m_req, 1);
      chk("wait_addr", bus.m_addr, addr);
      chk("wait_irdy", bus.i_ready, 0);
      chk("wait_drdy", bus.d_ready, 0);
    end
    bus.m_ack   = 1'b1;
    bus.m_rdata = rdata;
    step();
    bus.m_ack   = 1'b0;
    bus.i_flush = 1'b0;
    bus.m_rdata = $urandom;
    chk("resp_mreq", bus.m_req, 0);
    if (is_d) begin
      chk("resp_drdy", bus.d_ready, 1);
      chk("resp_drdata", bus.d_rdata, we ? 32'h0 : rdata);
      chk("resp_irdy_d", bus.i_ready, 0);
      last_d = we ? 32'h0 : rdata;
    end else begin
      if (fmode == 2) begin
        bus.i_flush = 1'b1;
        bus.i_req   = 1'b0;
        #1;
      end
      chk("resp_irdy", bus.i_ready, fmode == 0);
      chk("resp_drdy_i", bus.d_ready, 0);
      if (fmode == 0) begin
        chk("resp_irdata", bus.i_rdata, rdata);
        last_i  = rdata;
        i_known = 1'b1;
      end else begin
        i_known = 1'b0;
      end
    end
  endtask

  initial begin
    logic [29:0] a;
    logic [31:0] w, r;
    int          lat, kind, fm, cnt;
    bit          both;

    reset       = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.i_flush = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_rdata = '0;
    bus.m_ack   = 1'b0;
    i_known     = 1'b0;
    last_i      = '0;
    last_d      = '0;

    // Reset state
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_mreq", bus.m_req, 0);
    chk("rst_mwe", bus.m_we, 0);
    chk("rst_maddr", bus.m_addr, 0);
    chk("rst_mwdata", bus.m_wdata, 0);
    chk("rst_irdy", bus.i_ready, 0);
    chk("rst_drdy", bus.d_ready, 0);
    chk("rst_irdata", bus.i_rdata, 0);
    chk("rst_drdata", bus.d_rdata, 0);
`ifdef MEM_TIMEOUT_EN
    chk("rst_timeout", timeout, 0);
`endif
    reset = 1'b1;
    step();

    // Single fetch, ack two cycles after m_req rises
    bus.i_req  = 1'b1;
    bus.i_addr = 30'h100000;
    step();
    serve(0, 0, 30'h100000, 0, 2, 32'h8C080004, 0);
    bus.i_req = 1'b0;
    idle_chk();
    chk("fetch_hold", bus.i_rdata, 32'h8C080004);

    // Simultaneous requests: store first
    bus.i_req   = 1'b1;
    bus.i_addr  = 30'h100004;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 30'h4;
    bus.d_wdata = 32'hDEADBEEF;
    step();
    serve(1, 1, 30'h4, 32'hDEADBEEF, 1, 32'h12345678, 0);
    bus.d_req = 1'b0;
    idle_chk();
    step();
    serve(0, 0, 30'h100004, 0, 0, 32'h00000020, 0);
    bus.i_req = 1'b0;
    idle_chk();

    // Flush while the fetch is in flight
    bus.i_req  = 1'b1;
    bus.i_addr = 30'h100010;
    step();
    serve(0, 0, 30'h100010, 0, 2, 32'hBAD0BAD0, 1);
    idle_chk();
    bus.i_req  = 1'b1;
    bus.i_addr = 30'h100008;
    step();
    serve(0, 0, 30'h100008, 0, 1, 32'h24020001, 0);
    bus.i_req = 1'b0;
    idle_chk();

    // Flush in IDLE blocks that cycle's fetch grant
    bus.i_req   = 1'b1;
    bus.i_addr  = 30'h100020;
    bus.i_flush = 1'b1;
    step();
    chk("iflush_busy", busy, 0);
    chk("iflush_mreq", bus.m_req, 0);
    bus.i_flush = 1'b0;
    step();
    serve(0, 0, 30'h100020, 0, 0, 32'hCAFEF00D, 2);
    idle_chk();

    // Load raised during a fetch waits for it
    bus.i_req  = 1'b1;
    bus.i_addr = 30'h100030;
    step();
    bus.d_req = 1'b1;
    bus.d_we  = 1'b0;
    bus.d_addr = 30'h10;
    serve(0, 0, 30'h100030, 0, 2, 32'h01234567, 0);
    bus.i_req = 1'b0;
    idle_chk();
    step();
    serve(1, 0, 30'h10, 0, 1, 32'hA5A55A5A, 0);
    bus.d_req = 1'b0;
    idle_chk();
    chk("load_ihold", bus.i_rdata, 32'h01234567);

    // Stray m_ack in IDLE is ignored
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h77777777;
    step();
    bus.m_ack = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_drdy", bus.d_ready, 0);
    chk("stray_drdata", bus.d_rdata, last_d);
    chk("stray_irdata", bus.i_rdata, last_i);

    // Reset during D_WAIT abandons the store
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 30'h3C;
    bus.d_wdata = 32'h55AA55AA;
    step();
    chk("mid_mreq", bus.m_req, 1);
    reset = 1'b0;
    step();
    bus.d_req = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_mreq0", bus.m_req, 0);
    chk("mid_mwe", bus.m_we, 0);
    chk("mid_maddr", bus.m_addr, 0);
    chk("mid_mwdata", bus.m_wdata, 0);
    chk("mid_irdata", bus.i_rdata, 0);
    chk("mid_drdata", bus.d_rdata, 0);
    reset = 1'b1;
    i_known = 1'b1;
    last_i  = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mid_nodrdy", bus.d_ready, 0);
      chk("mid_idle", busy, 0);
    end

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      lat  = $urandom_range(0, 4);
      a    = 30'($urandom);
      w    = $urandom;
      r    = $urandom;
      if (kind == 0) begin
        fm = $urandom_range(0, 3);
        if (fm == 3) fm = 0;
        bus.i_req  = 1'b1;
        bus.i_addr = a;
        step();
        serve(0, 0, a, 0, lat, r, fm);
        bus.i_req = 1'b0;
        idle_chk();
      end else begin
        both = 1'($urandom_range(0, 1));
        bus.d_req   = 1'b1;
        bus.d_we    = (kind == 2);
        bus.d_addr  = a;
        bus.d_wdata = w;
        bus.i_req   = both;
        bus.i_addr  = ~a;
        step();
        serve(1, kind == 2, a, w, lat, r, 0);
        bus.d_req = 1'b0;
        if (i_known)
          chk("rnd_ihold", bus.i_rdata, last_i);
        idle_chk();
        if (both) begin
          step();
          serve(0, 0, ~a, 0, lat, ~r, 0);
          bus.i_req = 1'b0;
          idle_chk();
        end
      end
    end

`ifdef MEM_TIMEOUT_EN
    // No ack: watchdog gives up after 4 m_req cycles
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 30'h40;
    step();
    cnt = 0;
    for (int c = 0; c < 20 && bus.m_req; c++) begin
      cnt++;
      chk("to_nodrdy", bus.d_ready, 0);
      step();
    end
    bus.d_req = 1'b0;
    chk("to_cycles", cnt, 4);
    chk("to_flag", timeout, 1);
    chk("to_busy", busy, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("to_sticky", timeout, 1);
      chk("to_drdy", bus.d_ready, 0);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("to_clear", timeout, 0);
`else
    cnt = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the instruction-fetch stage (read-only) and the memory/writeback stage (read/write) of the pipelined MIPS machine.
- Sequences one memory transaction at a time and returns per-requester ready pulses, which the pipeline uses to stall fetch and memory stages.
- Sits between the pipeline's fetch/data ports and the external memory model.

Parameters:
ADDR_W, 30, word address width (byte address bits [31:2])
DATA_W, 32, data width
TIMEOUT_CYCLES, 64, max m_req-high cycles before timeout (only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low; asserted when 0
i_req  in  1  fetch request, held until i_ready or i_flush
i_addr  in  ADDR_W  fetch word address
i_flush  in  1  cancel outstanding fetch (branch taken)
i_rdata  out  DATA_W  fetched instruction, valid when i_ready
i_ready  out  1  one-cycle fetch-complete pulse
d_req  in  1  data request, held until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid when d_ready
d_ready  out  1  one-cycle data-complete pulse
m_req  out  1  memory request, held until m_ack
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid with m_ack
m_ack  in  1  one-cycle memory completion
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, D_WAIT, I_WAIT, D_RESP, I_RESP.
- Reset (reset==0 at edge): state=IDLE. All outputs 0: m_req, m_we, m_addr, m_wdata, i_ready, d_ready, i_rdata, d_rdata. discard flag cleared. Reset mid-transaction abandons it with no ready pulse.
- IDLE:
  - d_req=1 → D_WAIT. Latch d_we/d_addr/d_wdata. Data has fixed priority over fetch because it is the older instruction.
  - Else i_req=1 and i_flush=0 → I_WAIT. Latch i_addr, m_we=0.
  - Else stay.
- *_WAIT: m_req=1 with latched m_addr/m_we/m_wdata, stable until m_ack. On m_ack, capture m_rdata into the response register and move to the matching *_RESP.
- D_RESP: d_ready=1 for exactly one cycle, d_rdata=captured data (0 for stores), then → IDLE.
- I_RESP: i_ready=1 for one cycle unless discard is set, then → IDLE. i_rdata holds its value until the next fetch capture.
- Minimum latency: request seen in IDLE at cycle 0, m_req high from cycle 1; m_ack at cycle k gives ready at cycle k+1. Back-to-back transactions have one IDLE cycle between them.
- Flush:
  - i_flush in I_WAIT sets discard. The memory read still completes (it cannot be aborted); the response is dropped.
  - i_flush in I_RESP suppresses that i_ready.
  - i_flush in IDLE blocks a fetch grant that cycle.
  - discard clears on entry to IDLE.
  - i_flush has no effect on data transactions.
- m_ack outside *_WAIT is ignored.
- d_req arriving during a fetch waits; it is granted at the next IDLE ahead of any pending i_req.

Optional Feature:
- MEM_TIMEOUT_EN defined: adds port timeout (out, 1) and a cycle counter that clears on entering *_WAIT and increments while in *_WAIT.
  - Reaching TIMEOUT_CYCLES without m_ack: timeout=1 (sticky until reset), state → IDLE, m_req=0, no ready pulse for the abandoned request.
- Undefined: no counter, no timeout port; arbiter waits indefinitely for m_ack.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, D_WAIT, I_WAIT, D_RESP, I_RESP), default ADDR_W/DATA_W constants.
- One natural sub-module, mem_arb_watchdog: the timeout counter, instantiated only under MEM_TIMEOUT_EN.
- Response/latch registers reuse the existing register module.

Test Plan:
- Single fetch: i_req=1, i_addr=30'h100000, m_ack two cycles after m_req with m_rdata=32'h8C080004 → m_addr=30'h100000, m_we=0, i_ready pulses one cycle later with i_rdata=32'h8C080004.
- Simultaneous requests: i_req and d_req (d_we=1, d_addr=30'h4, d_wdata=32'hDEADBEEF) in same cycle → store issued first (m_we=1, m_wdata=32'hDEADBEEF), d_ready pulse, one IDLE cycle, then fetch issued.
- Flush in flight: fetch in I_WAIT, i_flush=1 one cycle, then m_ack → no i_ready; next i_req with new address (30'h100008) is served normally.
- Load during fetch: d_req (load, 30'h10) raised while I_WAIT → fetch completes, then load issues; d_rdata=m_rdata captured, d_ready single pulse.
- Reset mid-transaction: reset=0 during D_WAIT → next edge all outputs 0, state IDLE, no d_ready ever pulses for that request.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4: m_ack never asserted → timeout=1 after 4 cycles, m_req drops, busy=0, timeout stays 1 until reset.
